store_bus_unit: RTL

- Sits directly downstream of the store data generator; consumes its width-selected, zero-extended store word plus the effective address and store select.
- Lane-aligns the data by address offset, builds byte enables, runs a req/ack write transaction on the data-memory bus, stalls the pipeline until completion, and flags misaligned stores and bus faults.

---
 rtl/store_bus_unit_pkg.sv | 14 +
 rtl/store_bus_unit_if.sv | 36 +++
 rtl/store_bus_unit_lane_align.sv | 24 ++
 rtl/store_bus_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/store_bus_unit_pkg.sv
// store_bus_unit_pkg: store width encodings and FSM state type shared by the store bus unit.
package store_bus_unit_pkg;

    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/store_bus_unit_if.sv
// store_bus_unit_if: pipeline-side store inputs, data-memory bus and status signals of the store bus unit.
// slave modport: the store bus unit (takes I_*, drives O_*); master modport: its environment.
interface store_bus_unit_if #(
    parameter int CNT_W = 16
);

    logic             I_valid;
    logic [1:0]       I_storesel;
    logic [31:0]      I_addr;
    logic [31:0]      I_data;
    logic             O_stall;
    logic             O_bus_req;
    logic             O_bus_we;
    logic [31:0]      O_bus_addr;
    logic [31:0]      O_bus_wdata;
    logic [3:0]       O_bus_be;
    logic             I_bus_ack;
    logic             I_bus_err;
    logic             O_misaligned;
    logic             O_bus_fault;
    logic [31:0]      O_fault_addr;
    logic [CNT_W-1:0] O_store_count;

    modport slave (
        input  I_valid, I_storesel, I_addr, I_data, I_bus_ack, I_bus_err,
        output O_stall, O_bus_req, O_bus_we, O_bus_addr, O_bus_wdata, O_bus_be,
               O_misaligned, O_bus_fault, O_fault_addr, O_store_count
    );

    modport master (
        output I_valid, I_storesel, I_addr, I_data, I_bus_ack, I_bus_err,
        input  O_stall, O_bus_req, O_bus_we, O_bus_addr, O_bus_wdata, O_bus_be,
               O_misaligned, O_bus_fault, O_fault_addr, O_store_count
    );

endinterface

// File: rtl/store_bus_unit_lane_align.sv
// store_lane_align: places a zero-extended store word on its byte lanes and flags misaligned stores.
// Ports: storesel/off/data in; wdata (lane-aligned), be (byte enables), misaligned out.
module store_lane_align
    import store_bus_unit_pkg::*;
(
    input  logic [1:0]  storesel,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    logic is_sb;
    logic is_sh;

    // Any code other than SB/SH is treated as a full word.
    assign is_sb      = storesel == STORE_SB;
    assign is_sh      = storesel == STORE_SH;
    assign wdata      = is_sb ? data << {off, 3'b000} : is_sh ? data << {off[1], 4'b0000} : data;
    assign be         = is_sb ? 4'b0001 << off : is_sh ? 4'b0011 << off : 4'b1111;
    assign misaligned = is_sb ? 1'b0 : is_sh ? off[0] : off != 2'b00;

endmodule

// File: rtl/store_bus_unit.sv
// store_bus_unit: runs one req/ack data-memory write per aligned store, stalling the pipeline until it completes.
// Ports: I_clk, I_rstn (async active-low); bus (slave modport): store inputs, memory bus, fault/count status.
module store_bus_unit
    import store_bus_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input logic            I_clk,
    input logic            I_rstn,
    store_bus_unit_if.slave bus
);

    state_t           state;
    state_t           nxt;
    logic [31:0]      wdata_a;
    logic [3:0]       be_a;
    logic             mis_a;
    logic [31:0]      tcnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             mis_q;
    logic             fault_q;
    logic [31:0]      fault_addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             reject;
    logic             ok;
    logic             fault;
    logic             timed_out;

    store_lane_align u_align (
        .storesel   (bus.I_storesel),
        .off        (bus.I_addr[1:0]),
        .data       (bus.I_data),
        .wdata      (wdata_a),
        .be         (be_a),
        .misaligned (mis_a)
    );

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // An ack in the final timeout cycle takes priority over the timeout.
    always_comb begin
        nxt       = state;
        accept    = 1'b0;
        reject    = 1'b0;
        ok        = 1'b0;
        fault     = 1'b0;
        timed_out = (TIMEOUT_CYCLES > 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
        case (state)
            ST_IDLE: begin
                accept = bus.I_valid && !mis_a;
                reject = bus.I_valid && mis_a;
                nxt    = accept ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                ok    = bus.I_bus_ack && !bus.I_bus_err;
                fault = bus.I_bus_ack ? bus.I_bus_err : timed_out;
                nxt   = (bus.I_bus_ack || timed_out) ? ST_DONE : ST_REQ;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            tcnt         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            mis_q        <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cnt_q        <= '0;
        end else begin
            tcnt    <= (state == ST_REQ) ? tcnt + 32'd1 : '0;
            mis_q   <= reject;
            fault_q <= fault;
            if (accept) begin
                addr_q  <= bus.I_addr;
                wdata_q <= wdata_a;
                be_q    <= be_a;
            end
            if (reject)
                fault_addr_q <= bus.I_addr;
            else if (fault)
                fault_addr_q <= addr_q;
            if (ok)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Request is decoded from state so an async reset drops it at once.
    assign bus.O_stall       = accept || state == ST_REQ;
    assign bus.O_bus_req     = state == ST_REQ;
    assign bus.O_bus_we      = state == ST_REQ;
    assign bus.O_bus_addr    = {addr_q[31:2], 2'b00};
    assign bus.O_bus_wdata   = wdata_q;
    assign bus.O_bus_be      = be_q;
    assign bus.O_misaligned  = mis_q;
    assign bus.O_bus_fault   = fault_q;
    assign bus.O_fault_addr  = fault_addr_q;
    assign bus.O_store_count = cnt_q;

endmodule
